// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded fields from ID (*_id) and their registered EX copies (*_ex).
// The decode side is the master; the pipeline register is the slave.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              valid_id;
    logic              BranchB_id, BranchI_id, BranchGEQ_id, BranchLEQ_id;
    logic              MemToReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegWrite_id;
    logic [2:0]        ALUOp_id;
    logic [DATA_W-1:0] rd1_id, rd2_id, imm_id, pc_id;
    logic [REG_AW-1:0] rs1_id, rs2_id, rd_id;
    logic              use_rs1_id, use_rs2_id;

    logic              valid_ex;
    logic              BranchB_ex, BranchI_ex, BranchGEQ_ex, BranchLEQ_ex;
    logic              MemToReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex;
    logic [2:0]        ALUOp_ex;
    logic [DATA_W-1:0] rd1_ex, rd2_ex, imm_ex, pc_ex;
    logic [REG_AW-1:0] rs1_ex, rs2_ex, rd_ex;
    logic              use_rs1_ex, use_rs2_ex;

    modport master (
        output valid_id, BranchB_id, BranchI_id, BranchGEQ_id, BranchLEQ_id,
               MemToReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegWrite_id,
               ALUOp_id, rd1_id, rd2_id, imm_id, pc_id, rs1_id, rs2_id, rd_id,
               use_rs1_id, use_rs2_id,
        input  valid_ex, BranchB_ex, BranchI_ex, BranchGEQ_ex, BranchLEQ_ex,
               MemToReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex,
               ALUOp_ex, rd1_ex, rd2_ex, imm_ex, pc_ex, rs1_ex, rs2_ex, rd_ex,
               use_rs1_ex, use_rs2_ex
    );

    modport slave (
        input  valid_id, BranchB_id, BranchI_id, BranchGEQ_id, BranchLEQ_id,
               MemToReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegWrite_id,
               ALUOp_id, rd1_id, rd2_id, imm_id, pc_id, rs1_id, rs2_id, rd_id,
               use_rs1_id, use_rs2_id,
        output valid_ex, BranchB_ex, BranchI_ex, BranchGEQ_ex, BranchLEQ_ex,
               MemToReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex,
               ALUOp_ex, rd1_ex, rd2_ex, imm_ex, pc_ex, rs1_ex, rs2_ex, rd_ex,
               use_rs1_ex, use_rs2_ex
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use interlock and branch-flush bubbles.
// Optional ID_EX_HAZARD_STATS_EN adds saturating stall/flush event counters.
module id_ex_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    output logic                stall_o,
    id_ex_stage_reg_if.slave    bus
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    output logic [15:0]         stall_cnt_o,
    output logic [15:0]         flush_cnt_o
`endif
);

    // state     | meaning
    // RUN       | capture ID each edge, or bubble on a fresh load-use hazard
    // INTERLOCK | remaining load-latency cycles; bubble and hold the front end
    typedef enum logic [0:0] {RUN, INTERLOCK} state_t;

    typedef struct packed {
        logic              valid;
        logic              branch_b, branch_i, branch_geq, branch_leq;
        logic              mem_to_reg, mem_read, mem_write, alu_src, reg_write;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rd1, rd2, imm, pc;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic              use_rs1, use_rs2;
    } stage_t;

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    stage_t     ex_q, ex_d, id_w;
    logic       hazard;

    assign id_w = '{
        valid:      bus.valid_id,
        branch_b:   bus.BranchB_id,
        branch_i:   bus.BranchI_id,
        branch_geq: bus.BranchGEQ_id,
        branch_leq: bus.BranchLEQ_id,
        mem_to_reg: bus.MemToReg_id,
        mem_read:   bus.MemRead_id,
        mem_write:  bus.MemWrite_id,
        alu_src:    bus.ALUSrc_id,
        reg_write:  bus.RegWrite_id,
        alu_op:     bus.ALUOp_id,
        rd1:        bus.rd1_id,
        rd2:        bus.rd2_id,
        imm:        bus.imm_id,
        pc:         bus.pc_id,
        rs1:        bus.rs1_id,
        rs2:        bus.rs2_id,
        rd:         bus.rd_id,
        use_rs1:    bus.use_rs1_id,
        use_rs2:    bus.use_rs2_id
    };

    // Only a real load writing a nonzero register can create a hazard.
    assign hazard = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != '0) &
                    ((bus.use_rs1_id & (bus.rs1_id == ex_q.rd)) |
                     (bus.use_rs2_id & (bus.rs2_id == ex_q.rd))) &
                    bus.valid_id;

    assign stall_o = ~rst & ~flush_i &
                     (((state_q == RUN) & hazard) | (state_q == INTERLOCK));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        if (flush_i) begin
            ex_d    = '0;
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == INTERLOCK) begin
            ex_d = '0;
            if (cnt_q <= 4'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (hazard) begin
            ex_d = '0;
            if (LAT_M1 != 4'd0) begin
                state_d = INTERLOCK;
                cnt_d   = LAT_M1;
            end
        end else begin
            ex_d = id_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign bus.valid_ex     = ex_q.valid;
    assign bus.BranchB_ex   = ex_q.branch_b;
    assign bus.BranchI_ex   = ex_q.branch_i;
    assign bus.BranchGEQ_ex = ex_q.branch_geq;
    assign bus.BranchLEQ_ex = ex_q.branch_leq;
    assign bus.MemToReg_ex  = ex_q.mem_to_reg;
    assign bus.MemRead_ex   = ex_q.mem_read;
    assign bus.MemWrite_ex  = ex_q.mem_write;
    assign bus.ALUSrc_ex    = ex_q.alu_src;
    assign bus.RegWrite_ex  = ex_q.reg_write;
    assign bus.ALUOp_ex     = ex_q.alu_op;
    assign bus.rd1_ex       = ex_q.rd1;
    assign bus.rd2_ex       = ex_q.rd2;
    assign bus.imm_ex       = ex_q.imm;
    assign bus.pc_ex        = ex_q.pc;
    assign bus.rs1_ex       = ex_q.rs1;
    assign bus.rs2_ex       = ex_q.rs2;
    assign bus.rd_ex        = ex_q.rd;
    assign bus.use_rs1_ex   = ex_q.use_rs1;
    assign bus.use_rs2_ex   = ex_q.use_rs2;

`ifdef ID_EX_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_i && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
